// File: rtl/ffs_request_server.sv
// ffs_request_server: collects single-cycle request pulses into a pending
// vector and serves them lowest-index-first on a valid/ready output port.
//
// Handshake: out_valid is high whenever out_idx holds a served index. A transfer
// happens on a rising edge where out_valid && out_ready. While out_valid is high
// and out_ready is low, out_idx is held stable. out_valid never drops without
// a transfer, except on reset.
module ffs_request_server #(
  parameter int NENTRIES = 8,
  localparam int IDXW = $clog2(NENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NENTRIES-1:0] req_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDXW-1:0]     out_idx,
  output logic [NENTRIES-1:0] pending,
  output logic                dup_drop,
  output logic                state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [IDXW-1:0]     sel;
  logic                sel_found;
  logic                load;
  logic [NENTRIES-1:0] clear_mask;
  logic [NENTRIES-1:0] pending_d;

  // Fixed-priority scan: lowest set bit of pending wins. The bound is static.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NENTRIES; i++) begin
      if (!sel_found && pending[i]) begin
        sel       = IDXW'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Next-state and load decision. A load either starts serving from IDLE or
  // refills out_idx back-to-back after an accepted transfer.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    clear_mask = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          load    = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (out_ready) begin
          if (sel_found) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      clear_mask[sel] = 1'b1;
    end
  end

  // A new request wins over the clear of the bit being loaded this cycle, so
  // it survives as a fresh request.
  always_comb begin
    pending_d = (pending & ~clear_mask) | req_in;
  end

  // State, pending vector, held index and duplicate-request pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pending  <= '0;
      out_idx  <= '0;
      dup_drop <= 1'b0;
    end else begin
      state_q  <= state_d;
      pending  <= pending_d;
      dup_drop <= |(req_in & pending);
      if (load) begin
        out_idx <= sel;
      end
    end
  end

  assign out_valid = (state_q == OFFER);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ffs_request_server.sv
// Testbench for ffs_request_server: directed scenarios, expected indices are
// queued by the stimulus and consumed by an independent output monitor.
module tb_ffs_request_server;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
  logic         dup_drop;
  logic         state_dbg;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;

  ffs_request_server #(.NENTRIES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending),
    .dup_drop  (dup_drop),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and checks sample here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] r);
    req_in = r;
    tick();
    req_in = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got idx %0d expected none", out_idx);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_idx !== e) begin
          errors++;
          $display("FAIL xfer_idx: got %0d expected %0d", out_idx, e);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_in    = '1;
    out_ready = 1'b0;

    // Reset with all requests asserted: they must be ignored.
    repeat (3) tick();
    rst    = 1'b0;
    req_in = '0;
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_dup", 32'(dup_drop), 32'h0);
    check("rst_idx", 32'(out_idx), 32'h0);
    tick();
    check("rst_valid_after", 32'(out_valid), 32'h0);

    // Three requests drained back-to-back: 2, 5, 7.
    out_ready = 1'b1;
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd7);
    pulse(8'b1010_0100);
    check("burst_pending_t1", 32'(pending), 32'hA4);
    check("burst_valid_t1", 32'(out_valid), 32'h0);
    tick();
    check("burst_valid_t2", 32'(out_valid), 32'h1);
    check("burst_idx_t2", 32'(out_idx), 32'd2);
    tick();
    check("burst_idx_t3", 32'(out_idx), 32'd5);
    tick();
    check("burst_idx_t4", 32'(out_idx), 32'd7);
    tick();
    check("burst_valid_end", 32'(out_valid), 32'h0);
    check("burst_pending_end", 32'(pending), 32'h0);

    // Backpressure: index 0 held stable for 5 cycles, then 0 and 7.
    out_ready = 1'b0;
    pulse(8'h81);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(out_valid), 32'h1);
      check("hold_idx", 32'(out_idx), 32'd0);
      check("hold_pending", 32'(pending), 32'h80);
      tick();
    end
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd7);
    out_ready = 1'b1;
    tick();
    check("hold_idx_next", 32'(out_idx), 32'd7);
    tick();
    check("hold_valid_end", 32'(out_valid), 32'h0);

    // Re-request of the held index, then a duplicate of that re-request.
    out_ready = 1'b0;
    exp_q.push_back(3'd3);
    pulse(8'h08);
    tick();
    check("rereq_idx", 32'(out_idx), 32'd3);
    check("rereq_pending0", 32'(pending), 32'h0);
    pulse(8'h08);
    check("rereq_pending1", 32'(pending), 32'h08);
    check("rereq_dup0", 32'(dup_drop), 32'h0);
    pulse(8'h08);
    check("dup_pending", 32'(pending), 32'h08);
    check("dup_pulse", 32'(dup_drop), 32'h1);
    tick();
    check("dup_clear", 32'(dup_drop), 32'h0);
    exp_q.push_back(3'd3);
    out_ready = 1'b1;
    tick();
    check("rereq_idx2", 32'(out_idx), 32'd3);
    check("rereq_valid2", 32'(out_valid), 32'h1);
    tick();
    check("rereq_valid_end", 32'(out_valid), 32'h0);

    // Request for index 4 arriving in the very cycle 4 is loaded.
    out_ready = 1'b0;
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd4);
    pulse(8'h10);
    pulse(8'h10);
    check("same_idx", 32'(out_idx), 32'd4);
    check("same_valid", 32'(out_valid), 32'h1);
    check("same_pending", 32'(pending), 32'h10);
    out_ready = 1'b1;
    tick();
    check("same_idx2", 32'(out_idx), 32'd4);
    check("same_pending2", 32'(pending), 32'h0);
    tick();
    check("same_valid_end", 32'(out_valid), 32'h0);

    // Reset while offering with pending = F0: everything discarded.
    out_ready = 1'b0;
    pulse(8'h01);
    pulse(8'hF0);
    check("prerst_valid", 32'(out_valid), 32'h1);
    check("prerst_pending", 32'(pending), 32'hF0);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_pending", 32'(pending), 32'h0);
    repeat (4) tick();
    check("midrst_quiet", 32'(out_valid), 32'h0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
